// File: rtl/commit_if.sv
// Retirement-side bus of the commit stage: ROB head view, architectural
// register file write, free-list return, flush and retired-instruction count.
interface commit_if #(
   parameter int PHYS_W = 6,
   parameter int ARCH_W = 5,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 32
);
   logic              head_valid;
   logic              head_done;
   logic              head_exc;
   logic              head_has_dest;
   logic [ARCH_W-1:0] head_arch_rd;
   logic [PHYS_W-1:0] head_phys_rd;
   logic [PHYS_W-1:0] head_old_phys_rd;
   logic [DATA_W-1:0] head_value;
   logic [31:0]       head_pc;
   logic              head_pop;

   logic              rf_we;
   logic [ARCH_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;

   // free_valid/free_reg form a valid/ready channel: once free_valid rises,
   // free_valid and free_reg stay stable until a rising clock edge with
   // free_ready high transfers free_reg to the free list.
   logic              free_valid;
   logic [PHYS_W-1:0] free_reg;
   logic              free_ready;

   logic              flush;
   logic [31:0]       flush_pc;
   logic [CNT_W-1:0]  retire_count;

   modport master (
      output head_valid, head_done, head_exc, head_has_dest, head_arch_rd,
             head_phys_rd, head_old_phys_rd, head_value, head_pc, free_ready,
      input  head_pop, rf_we, rf_waddr, rf_wdata, free_valid, free_reg,
             flush, flush_pc, retire_count
   );

   modport slave (
      input  head_valid, head_done, head_exc, head_has_dest, head_arch_rd,
             head_phys_rd, head_old_phys_rd, head_value, head_pc, free_ready,
      output head_pop, rf_we, rf_waddr, rf_wdata, free_valid, free_reg,
             flush, flush_pc, retire_count
   );
endinterface

// File: rtl/commit_unit.sv
// In-order retirement: pops a completed ROB head, writes the architectural
// register file, returns the superseded physical register, flushes on exceptions.
module commit_unit #(
   parameter int PHYS_W = 6,
   parameter int ARCH_W = 5,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic    clk,
   input  logic    reset,
   commit_if.slave cu,
   output logic    state_dbg
);
   typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

   state_t state, state_n;

   logic              free_stall;
   logic              commit;
   logic              exc_take;
   logic              writes_rf;
   logic              frees_reg;

   logic              rf_we_q;
   logic [ARCH_W-1:0] rf_waddr_q;
   logic [DATA_W-1:0] rf_wdata_q;
   logic              free_valid_q;
   logic [PHYS_W-1:0] free_reg_q;
   logic              flush_q;
   logic [31:0]       flush_pc_q;
   logic [CNT_W-1:0]  count_q;

   // The new physical destination is already architecturally mapped by rename.
   logic unused_phys;
   assign unused_phys = ^cu.head_phys_rd;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= RUN;
      else       state <= state_n;
   end

   always_comb begin
      state_n    = state;
      commit     = 1'b0;
      exc_take   = 1'b0;
      free_stall = free_valid_q & ~cu.free_ready;
      writes_rf  = cu.head_has_dest & (cu.head_arch_rd != '0);
      frees_reg  = cu.head_has_dest & (cu.head_old_phys_rd != '0);
      case (state)
         RUN: begin
            commit   = ~reset & cu.head_valid & cu.head_done & ~cu.head_exc & ~free_stall;
            exc_take = cu.head_valid & cu.head_done & cu.head_exc;
            if (exc_take) state_n = FLUSH;
         end
         FLUSH: begin
            // Leave only once the ROB has been emptied by the flush.
            if (!cu.head_valid) state_n = RUN;
         end
         default: state_n = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rf_we_q      <= 1'b0;
         rf_waddr_q   <= '0;
         rf_wdata_q   <= '0;
         free_valid_q <= 1'b0;
         free_reg_q   <= '0;
         flush_q      <= 1'b0;
         flush_pc_q   <= '0;
         count_q      <= '0;
      end else begin
         rf_we_q <= commit & writes_rf;
         if (commit) begin
            rf_waddr_q <= cu.head_arch_rd;
            rf_wdata_q <= cu.head_value;
            count_q    <= count_q + CNT_W'(1);
         end
         // A commit only happens when the free channel is empty or draining,
         // so loading a new entry never overwrites an unaccepted one.
         if (commit & frees_reg) begin
            free_valid_q <= 1'b1;
            free_reg_q   <= cu.head_old_phys_rd;
         end else if (free_valid_q & cu.free_ready) begin
            free_valid_q <= 1'b0;
            free_reg_q   <= '0;
         end
         flush_q <= exc_take;
         if (exc_take) flush_pc_q <= cu.head_pc;
      end
   end

   assign cu.head_pop     = commit;
   assign cu.rf_we        = rf_we_q;
   assign cu.rf_waddr     = rf_waddr_q;
   assign cu.rf_wdata     = rf_wdata_q;
   assign cu.free_valid   = free_valid_q;
   assign cu.free_reg     = free_reg_q;
   assign cu.flush        = flush_q;
   assign cu.flush_pc     = flush_pc_q;
   assign cu.retire_count = count_q;
   assign state_dbg       = state;
endmodule

// File: tb/tb_commit_unit.sv
// Self-checking bench for commit_unit: directed retirement scenarios with a
// scoreboard of expected register-file writes and free-list returns.
module tb_commit_unit;
   localparam int PHYS_W = 6;
   localparam int ARCH_W = 5;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;   // narrow so the counter wrap is reachable

   logic clk = 1'b0;
   logic reset;
   logic state_dbg;

   always #5 clk = ~clk;

   commit_if #(.PHYS_W(PHYS_W), .ARCH_W(ARCH_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

   commit_unit #(.PHYS_W(PHYS_W), .ARCH_W(ARCH_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .cu        (bus),
      .state_dbg (state_dbg)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [ARCH_W+DATA_W-1:0] rf_exp_q[$];
   logic [PHYS_W-1:0]        free_exp_q[$];
   logic [CNT_W-1:0]         exp_count;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic drive_head(input logic v, input logic d, input logic e, input logic hd,
                             input logic [ARCH_W-1:0] arch, input logic [PHYS_W-1:0] old,
                             input logic [DATA_W-1:0] val, input logic [31:0] pc);
      bus.head_valid       = v;
      bus.head_done        = d;
      bus.head_exc         = e;
      bus.head_has_dest    = hd;
      bus.head_arch_rd     = arch;
      bus.head_phys_rd     = PHYS_W'($urandom_range(0, 63));
      bus.head_old_phys_rd = old;
      bus.head_value       = val;
      bus.head_pc          = pc;
   endtask

   task automatic idle();
      drive_head(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
   endtask

   task automatic expect_commit(input logic hd, input logic [ARCH_W-1:0] arch,
                                input logic [PHYS_W-1:0] old, input logic [DATA_W-1:0] val);
      if (hd && arch != '0) rf_exp_q.push_back({arch, val});
      if (hd && old != '0)  free_exp_q.push_back(old);
      exp_count++;
   endtask

   // Drives one completed head that must be popped this cycle.
   task automatic commit_step(input logic hd, input logic [ARCH_W-1:0] arch,
                              input logic [PHYS_W-1:0] old, input logic [DATA_W-1:0] val);
      drive_head(1'b1, 1'b1, 1'b0, hd, arch, old, val, 32'h1000);
      expect_commit(hd, arch, old, val);
      sample();
      check("head_pop_commit", 64'(bus.head_pop), 64'd1);
      next_cycle();
   endtask

   task automatic commit_random();
      commit_step(1'b1, ARCH_W'($urandom_range(0, 31)), PHYS_W'($urandom_range(0, 63)),
                  DATA_W'($urandom));
   endtask

   always @(negedge clk) begin
      if (reset === 1'b0) begin
         if (bus.rf_we) begin
            if (rf_exp_q.size() == 0) begin
               check("rf_unexpected_write", 64'(bus.rf_waddr), 64'hFFFF);
            end else begin
               logic [ARCH_W+DATA_W-1:0] e;
               e = rf_exp_q.pop_front();
               check("rf_waddr", 64'(bus.rf_waddr), 64'(e[ARCH_W+DATA_W-1:DATA_W]));
               check("rf_wdata", 64'(bus.rf_wdata), 64'(e[DATA_W-1:0]));
            end
         end
         if (bus.free_valid && bus.free_ready) begin
            if (free_exp_q.size() == 0) begin
               check("free_unexpected", 64'(bus.free_reg), 64'hFFFF);
            end else begin
               logic [PHYS_W-1:0] f;
               f = free_exp_q.pop_front();
               check("free_reg", 64'(bus.free_reg), 64'(f));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_count      = '0;
      reset          = 1'b1;
      bus.free_ready = 1'b1;
      // Completed head present during reset must not be popped.
      drive_head(1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 6'd7, 32'h1234, 32'h0);
      sample();
      check("reset_head_pop", 64'(bus.head_pop), 64'd0);
      check("reset_rf_we", 64'(bus.rf_we), 64'd0);
      check("reset_rf_waddr", 64'(bus.rf_waddr), 64'd0);
      check("reset_rf_wdata", 64'(bus.rf_wdata), 64'd0);
      check("reset_free_valid", 64'(bus.free_valid), 64'd0);
      check("reset_free_reg", 64'(bus.free_reg), 64'd0);
      check("reset_flush", 64'(bus.flush), 64'd0);
      check("reset_flush_pc", 64'(bus.flush_pc), 64'd0);
      check("reset_count", 64'(bus.retire_count), 64'd0);
      check("reset_state", 64'(state_dbg), 64'd0);
      next_cycle();
      idle();
      reset = 1'b0;
      next_cycle();

      // Basic commit with register write and free return.
      commit_step(1'b1, 5'd5, 6'd12, 32'hDEADBEEF);
      idle();
      sample();
      check("t1_rf_we", 64'(bus.rf_we), 64'd1);
      check("t1_rf_waddr", 64'(bus.rf_waddr), 64'd5);
      check("t1_rf_wdata", 64'(bus.rf_wdata), 64'hDEADBEEF);
      check("t1_free_valid", 64'(bus.free_valid), 64'd1);
      check("t1_free_reg", 64'(bus.free_reg), 64'd12);
      check("t1_count", 64'(bus.retire_count), 64'd1);
      next_cycle();

      // Free-list back-pressure holds the pending return and blocks commits.
      bus.free_ready = 1'b0;
      commit_step(1'b1, 5'd6, 6'd20, 32'hA5A5_0006);
      drive_head(1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 6'd21, 32'h0BAD_F00D, 32'h2000);
      for (int i = 0; i < 3; i++) begin
         sample();
         check("t2_stall_pop", 64'(bus.head_pop), 64'd0);
         check("t2_stall_free_valid", 64'(bus.free_valid), 64'd1);
         check("t2_stall_free_reg", 64'(bus.free_reg), 64'd20);
         next_cycle();
      end
      bus.free_ready = 1'b1;
      expect_commit(1'b1, 5'd7, 6'd21, 32'h0BAD_F00D);
      sample();
      check("t2_resume_pop", 64'(bus.head_pop), 64'd1);
      next_cycle();
      idle();
      sample();
      check("t2_free_reg_new", 64'(bus.free_reg), 64'd21);
      check("t2_count", 64'(bus.retire_count), 64'(exp_count));
      next_cycle();

      // Destination x0 with old p0: retire without side effects.
      commit_step(1'b1, 5'd0, 6'd0, 32'h1111_2222);
      idle();
      sample();
      check("t3_rf_we", 64'(bus.rf_we), 64'd0);
      check("t3_free_valid", 64'(bus.free_valid), 64'd0);
      check("t3_count", 64'(bus.retire_count), 64'(exp_count));
      next_cycle();
      commit_step(1'b0, 5'd9, 6'd9, 32'h3333_4444);
      idle();
      sample();
      check("t3b_rf_we", 64'(bus.rf_we), 64'd0);
      check("t3b_free_valid", 64'(bus.free_valid), 64'd0);
      next_cycle();

      // Head not yet done: wait without side effects.
      drive_head(1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 6'd4, 32'h5555, 32'h3000);
      for (int i = 0; i < 4; i++) begin
         sample();
         check("wait_pop", 64'(bus.head_pop), 64'd0);
         next_cycle();
      end
      sample();
      check("wait_count", 64'(bus.retire_count), 64'(exp_count));
      next_cycle();

      // Exception: one-cycle flush, no commits until the ROB drains.
      drive_head(1'b1, 1'b1, 1'b1, 1'b1, 5'd8, 6'd9, 32'h7777, 32'h40);
      sample();
      check("t4_exc_pop", 64'(bus.head_pop), 64'd0);
      next_cycle();
      sample();
      check("t4_flush", 64'(bus.flush), 64'd1);
      check("t4_flush_pc", 64'(bus.flush_pc), 64'h40);
      check("t4_state_flush", 64'(state_dbg), 64'd1);
      check("t4_flush_pop", 64'(bus.head_pop), 64'd0);
      next_cycle();
      drive_head(1'b1, 1'b1, 1'b0, 1'b1, 5'd8, 6'd9, 32'h8888, 32'h44);
      sample();
      check("t4_flush_one_cycle", 64'(bus.flush), 64'd0);
      check("t4_no_pop_in_flush", 64'(bus.head_pop), 64'd0);
      check("t4_count_hold", 64'(bus.retire_count), 64'(exp_count));
      next_cycle();
      idle();
      next_cycle();
      commit_step(1'b1, 5'd10, 6'd11, 32'hCAFE_0010);
      idle();
      sample();
      check("t4_state_run", 64'(state_dbg), 64'd0);
      check("t4_count", 64'(bus.retire_count), 64'(exp_count));
      next_cycle();

      // Back-to-back commits, then run the counter up to its wrap.
      for (int i = 0; i < 4; i++) commit_random();
      idle();
      sample();
      check("t5_b2b_count", 64'(bus.retire_count), 64'(exp_count));
      next_cycle();
      while (exp_count != {CNT_W{1'b1}}) commit_random();
      idle();
      sample();
      check("t5_count_max", 64'(bus.retire_count), 64'hF);
      next_cycle();
      commit_random();
      idle();
      sample();
      check("t5_count_wrap", 64'(bus.retire_count), 64'd0);
      next_cycle();

      // Reset while a free return is pending and the unit is flushing.
      bus.free_ready = 1'b0;
      commit_step(1'b1, 5'd12, 6'd33, 32'h0000_0C0C);
      drive_head(1'b1, 1'b1, 1'b1, 1'b0, '0, '0, '0, 32'h80);
      sample();
      check("t6_exc_pop", 64'(bus.head_pop), 64'd0);
      next_cycle();
      sample();
      check("t6_flush", 64'(bus.flush), 64'd1);
      check("t6_flush_pc", 64'(bus.flush_pc), 64'h80);
      check("t6_free_pending", 64'(bus.free_valid), 64'd1);
      check("t6_state_flush", 64'(state_dbg), 64'd1);
      reset = 1'b1;
      #1;
      free_exp_q.delete();
      exp_count = '0;
      check("t6_rst_free_valid", 64'(bus.free_valid), 64'd0);
      check("t6_rst_free_reg", 64'(bus.free_reg), 64'd0);
      check("t6_rst_flush", 64'(bus.flush), 64'd0);
      check("t6_rst_flush_pc", 64'(bus.flush_pc), 64'd0);
      check("t6_rst_count", 64'(bus.retire_count), 64'd0);
      check("t6_rst_rf_we", 64'(bus.rf_we), 64'd0);
      check("t6_rst_pop", 64'(bus.head_pop), 64'd0);
      check("t6_rst_state", 64'(state_dbg), 64'd0);
      next_cycle();
      idle();
      bus.free_ready = 1'b1;
      reset = 1'b0;
      sample();
      check("t6_state_after", 64'(state_dbg), 64'd0);
      next_cycle();
      commit_step(1'b1, 5'd13, 6'd14, 32'hF00D_0013);
      idle();
      sample();
      check("t6_post_rf_we", 64'(bus.rf_we), 64'd1);
      check("t6_post_count", 64'(bus.retire_count), 64'd1);
      next_cycle();
      next_cycle();

      check("rf_queue_drained", 64'(rf_exp_q.size()), 64'd0);
      check("free_queue_drained", 64'(free_exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
